// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer
// Ping-pong serial-to-parallel frame buffer between the FIR and the FFT.
// FIR samples are packed into N-sample frames, alternating between two banks.
// Each completed bank is presented in parallel through a valid/ready handshake.
// While the FFT drains one bank, the other bank keeps filling.

module fft_frame_buffer #(
   parameter int DW = 16,
   parameter int N  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fir_valid,
   input  logic signed [DW-1:0] fir_d,
   input  logic                 frame_ready,
   output logic                 frame_valid,
   output logic [N*DW-1:0]      frame_data,
   output logic [7:0]           frame_index,
   output logic                 overflow
);

   localparam int              CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

   // Sample storage: two banks of N registers each.
   logic signed [DW-1:0] mem_q [2][N];
   logic signed [DW-1:0] mem_d [2][N];

   // Bank bookkeeping.
   logic [1:0]    full_q,        full_d;
   logic          wr_bank_q,     wr_bank_d;
   logic          rd_bank_q,     rd_bank_d;
   logic [CW-1:0] wr_cnt_q,      wr_cnt_d;
   logic [7:0]    frame_index_q, frame_index_d;
   logic          overflow_q,    overflow_d;

   // Per-cycle decisions.
   logic wr_en;
   logic wr_drop;
   logic wr_last;
   logic rd_xfer;

   // Write/read decisions, and the next state of flags, pointers and counters.
   // Both decisions use the registered full flags. A bank released this cycle
   // therefore cannot also take a sample this cycle.
   always_comb begin
      wr_en         = fir_valid && !full_q[wr_bank_q];
      wr_drop       = fir_valid &&  full_q[wr_bank_q];
      wr_last       = wr_en && (wr_cnt_q == LAST_IDX);
      rd_xfer       = full_q[rd_bank_q] && frame_ready;

      full_d        = full_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      wr_cnt_d      = wr_cnt_q;
      frame_index_d = frame_index_q;
      overflow_d    = overflow_q;

      if (wr_en) begin
         if (wr_last) begin
            wr_cnt_d          = '0;
            wr_bank_d         = ~wr_bank_q;
            full_d[wr_bank_q] = 1'b1;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      if (wr_drop) begin
         overflow_d = 1'b1;
      end

      // The read-clear never hits the write bank, so it can follow the write-set.
      if (rd_xfer) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         frame_index_d     = frame_index_q + 8'd1;
      end
   end

   // Bank contents: only the addressed slot of the write bank changes.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_bank_q][wr_cnt_q] = fir_d;
      end
   end

   // State registers. Reset clears everything, including the sample banks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q        <= '0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         wr_cnt_q      <= '0;
         frame_index_q <= '0;
         overflow_q    <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N; k++) begin
               mem_q[b][k] <= '0;
            end
         end
      end else begin
         full_q        <= full_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         wr_cnt_q      <= wr_cnt_d;
         frame_index_q <= frame_index_d;
         overflow_q    <= overflow_d;
         mem_q         <= mem_d;
      end
   end

   // Read side: present the bank under the read pointer.
   assign frame_valid = full_q[rd_bank_q];
   assign frame_index = frame_index_q;
   assign overflow    = overflow_q;

   for (genvar k = 0; k < N; k++) begin : g_frame_out
      assign frame_data[k*DW +: DW] = mem_q[rd_bank_q][k];
   end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb_fft_frame_buffer
// Directed bench for fft_frame_buffer (DW=16, N=16) with hand-derived frames.

module tb_fft_frame_buffer;

   localparam int DW = 16;
   localparam int N  = 16;
   localparam int FW = N * DW;

   logic                 clk;
   logic                 rst;
   logic                 fir_valid;
   logic signed [DW-1:0] fir_d;
   logic                 frame_ready;
   logic                 frame_valid;
   logic [FW-1:0]        frame_data;
   logic [7:0]           frame_index;
   logic                 overflow;

   int checks;
   int errors;

   fft_frame_buffer #(.DW(DW), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .fir_valid   (fir_valid),
      .fir_d       (fir_d),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_index (frame_index),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk_frame(input int base);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < N; k++) f[k*DW +: DW] = DW'(base + k);
      return f;
   endfunction

   // Advance one clock; outputs are then read 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      fir_valid = 1'b1;
      fir_d     = DW'(v);
      tick();
      fir_valid = 1'b0;
   endtask

   task automatic accept();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", FW'(frame_valid), '0);
      chk("rst_index", FW'(frame_index), '0);
      chk("rst_ovf",   FW'(overflow),    '0);
      chk("rst_data",  frame_data,       '0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      fir_valid   = 1'b0;
      fir_d       = '0;
      frame_ready = 1'b0;
      tick();
      rst = 1'b0;

      // Single frame, values 1..16, held until accepted.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         send(i);
         if (i == 15) chk("single_not_yet", FW'(frame_valid), FW'(1'b0));
      end
      chk("single_valid", FW'(frame_valid), FW'(1'b1));
      chk("single_data",  frame_data,       mk_frame(1));
      chk("single_index", FW'(frame_index), FW'(8'd0));
      tick();
      tick();
      chk("single_hold_valid", FW'(frame_valid), FW'(1'b1));
      chk("single_hold_data",  frame_data,       mk_frame(1));
      accept();
      chk("single_drop", FW'(frame_valid), FW'(1'b0));
      chk("single_idx1", FW'(frame_index), FW'(8'd1));

      // Continuous stream 0..63 with the FFT always ready.
      do_reset();
      frame_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         send(i);
         if (i % 16 == 15) begin
            chk($sformatf("cont_valid%0d", i / 16), FW'(frame_valid), FW'(1'b1));
            chk($sformatf("cont_idx%0d",   i / 16), FW'(frame_index), FW'(i / 16));
            chk($sformatf("cont_data%0d",  i / 16), frame_data,       mk_frame(i - 15));
         end else if (i % 16 == 0 && i > 0) begin
            chk($sformatf("cont_gap%0d", i), FW'(frame_valid), FW'(1'b0));
         end
      end
      tick();
      frame_ready = 1'b0;
      chk("cont_done_valid", FW'(frame_valid), FW'(1'b0));
      chk("cont_done_idx",   FW'(frame_index), FW'(8'd4));
      chk("cont_ovf",        FW'(overflow),    FW'(1'b0));

      // Overflow: 40 samples, nothing accepted.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         send(i);
         if (i == 31) chk("ovf_before", FW'(overflow), FW'(1'b0));
         if (i == 32) chk("ovf_rise",   FW'(overflow), FW'(1'b1));
      end
      chk("ovf_f0_data", frame_data,       mk_frame(0));
      chk("ovf_f0_idx",  FW'(frame_index), FW'(8'd0));
      accept();
      chk("ovf_f1_valid", FW'(frame_valid), FW'(1'b1));
      chk("ovf_f1_data",  frame_data,       mk_frame(16));
      chk("ovf_f1_idx",   FW'(frame_index), FW'(8'd1));
      accept();
      chk("ovf_empty", FW'(frame_valid), FW'(1'b0));
      for (int i = 40; i < 56; i++) send(i);
      chk("ovf_f2_valid", FW'(frame_valid), FW'(1'b1));
      chk("ovf_f2_data",  frame_data,       mk_frame(40));
      chk("ovf_f2_idx",   FW'(frame_index), FW'(8'd2));
      chk("ovf_sticky",   FW'(overflow),    FW'(1'b1));

      // Gaps: fir_valid toggling 1,0,1,0...
      do_reset();
      for (int i = 0; i < 16; i++) begin
         send(100 + i);
         if (i == 15) begin
            chk("gap_valid", FW'(frame_valid), FW'(1'b1));
            chk("gap_data",  frame_data,       mk_frame(100));
         end else begin
            tick();
            if (i == 14) chk("gap_not_yet", FW'(frame_valid), FW'(1'b0));
         end
      end

      // Release collision: both banks full, accept and new sample same edge.
      do_reset();
      for (int i = 0; i < 32; i++) send(i);
      chk("coll_pre_ovf", FW'(overflow), FW'(1'b0));
      frame_ready = 1'b1;
      send(999);
      frame_ready = 1'b0;
      chk("coll_ovf",     FW'(overflow),    FW'(1'b1));
      chk("coll_f1_data", frame_data,       mk_frame(16));
      chk("coll_f1_idx",  FW'(frame_index), FW'(8'd1));
      for (int i = 200; i < 216; i++) send(i);
      accept();
      chk("coll_f2_valid", FW'(frame_valid), FW'(1'b1));
      chk("coll_f2_data",  frame_data,       mk_frame(200));
      chk("coll_f2_idx",   FW'(frame_index), FW'(8'd2));

      // Frame index wrap over 257 frames.
      do_reset();
      frame_ready = 1'b1;
      for (int f = 0; f < 257; f++) begin
         for (int k = 0; k < 16; k++) send(f * 16 + k);
         if (f == 0 || f == 255 || f == 256) begin
            chk($sformatf("wrap_idx%0d", f), FW'(frame_index), FW'(f % 256));
         end
         if (f == 256) chk("wrap_data", frame_data, mk_frame(4096));
      end
      tick();
      frame_ready = 1'b0;
      chk("wrap_after", FW'(frame_index), FW'(8'd1));

      // Asynchronous reset mid-frame with a full frame pending.
      for (int i = 0; i < 16; i++) send(i + 1);
      for (int i = 0; i < 7; i++)  send(50 + i);
      chk("arst_pre_valid", FW'(frame_valid), FW'(1'b1));
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", FW'(frame_valid), '0);
      chk("arst_data",  frame_data,       '0);
      chk("arst_idx",   FW'(frame_index), '0);
      #1 rst = 1'b0;
      tick();
      for (int i = 300; i < 316; i++) send(i);
      chk("arst_f_valid", FW'(frame_valid), FW'(1'b1));
      chk("arst_f_data",  frame_data,       mk_frame(300));
      chk("arst_f_idx",   FW'(frame_index), FW'(8'd0));
      chk("arst_f_ovf",   FW'(overflow),    FW'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Ping-pong serial-to-parallel buffer that sits directly downstream of the 32-tap FIR stage. It collects consecutive `fir_d` samples qualified by `fir_valid` into frames of N samples, alternating between two banks. It presents each completed frame in parallel to the FFT stage through a valid/ready handshake, so the FIR can keep streaming while the FFT consumes the previous frame.

## Interface
- `DW`, default 16: sample width, two's complement.
- `N`, default 16: samples per frame; power of two, 2..64.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fir_valid`  in  1  sample strobe from FIR; one sample per cycle while high.
- `fir_d`  in  DW  signed sample, captured when `fir_valid`=1.
- `frame_ready`  in  1  FFT accepts the presented frame this cycle.
- `frame_valid`  out  1  a complete frame is presented.
- `frame_data`  out  N*DW  frame; sample k (k-th accepted in frame) at bits [k*DW +: DW].
- `frame_index`  out  8  sequence number of the presented frame, mod 256.
- `overflow`  out  1  sticky: at least one sample was discarded.

## Operation
- Storage: two banks (0, 1) of N×DW registers, a `full[1:0]` flag per bank, write pointer `wr_bank`, write counter `wr_cnt` (log2 N bits), read pointer `rd_bank`, frame counter `frame_index`.
- Write side, on each cycle with `fir_valid`=1:
  - if `full[wr_bank]`=0: bank[`wr_bank`][`wr_cnt`] <= `fir_d`; `wr_cnt`++.
  - if `wr_cnt`=N-1 on that write: set `full[wr_bank]`, toggle `wr_bank`, `wr_cnt` <= 0.
  - if `full[wr_bank]`=1 (both banks occupied): sample discarded, `overflow` <= 1, `wr_cnt` unchanged (stays 0).
- Gaps: `fir_valid` low mid-frame holds `wr_cnt` and bank contents; the frame resumes on the next valid sample. No timeout, no flush.
- Read side: `frame_valid` = `full[rd_bank]`; `frame_data` = bank[`rd_bank`] (mux of registers). Transfer occurs when `frame_valid` && `frame_ready`: clear `full[rd_bank]`, toggle `rd_bank`, `frame_index`++ (wraps 255→0).
- `frame_ready` while `frame_valid`=0 has no effect.
- Overflow is sticky until `rst`. The discarded samples are lost; no realignment is performed.
- Flag arbitration per cycle, per bank: write-set and read-clear always target different banks in the same cycle, because the write bank is never full when written. Both take effect.
- Same-cycle release and new sample on the bank being released: the decision uses the registered `full` value, so the sample is discarded and `overflow` is set. The bank is writable from the next cycle.

## Timing
- Reset values: `frame_valid`=0, `frame_data`=0 (all bank registers cleared), `frame_index`=0, `overflow`=0. Internally `wr_bank`=0, `rd_bank`=0, `wr_cnt`=0, `full`=00.
- Latency: the N-th sample is captured at edge E; `frame_valid`=1 after E, in the same cycle the FIR presents sample N+1.
- `frame_data` and `frame_index` are stable while `frame_valid`=1 and not yet accepted.
- Handshake completes on the edge where both `frame_valid` and `frame_ready` are high. The next frame may be valid in the immediately following cycle (back-to-back frames, no bubble).
- Throughput: sustained one sample/cycle with no loss if each frame is accepted within N cycles of becoming valid.
- `overflow` rises on the edge of the first discarded sample.
- Asynchronous `rst` mid-frame: all outputs go to their reset values immediately, partial and full frames are lost, and the next valid sample is written to bank 0 index 0.

## Test plan
- Single frame (N=16): drive `fir_d`=1..16 on 16 consecutive cycles, `frame_ready`=0. Required: `frame_valid`=1 from the cycle after the 16th sample, `frame_data` sample k = k+1, `frame_index`=0. Pulse `frame_ready` and `frame_valid` drops next cycle.
- Continuous stream: 64 samples 0..63, `frame_ready`=1 throughout. Required: four frames with indices 0..3, frame j holds 16j..16j+15, `overflow`=0.
- Overflow: 40 samples 0..39, `frame_ready`=0. Required: frames {0..15} and {16..31} held; samples 32..39 discarded; `overflow`=1 from sample 32. After two accepts, sample 40 lands at index 0 of the freed bank.
- Gaps: 16 samples with `fir_valid` toggling 1,0,1,0…. Required: one frame with values in arrival order, valid the cycle after the last sample.
- Release collision: both banks full, `frame_ready`=1 in the same cycle as a new sample. Required: sample discarded, `overflow`=1, following sample written at index 0.
- Reset and wrap: run 257 frames with `frame_ready`=1 and check `frame_index` wraps 255→0. Assert `rst` after 7 samples of a frame; all outputs go to 0 and the next frame starts at sample index 0 with `frame_index`=0.
